// File: rtl/fixed_softplus_backward.sv
// Softplus backward pass: dL/dx = dL/dy * sigmoid(x), sigmoid from a symmetric piecewise-quadratic fit.
// Latency 3 cycles (|x| + first Horner step, second Horner step + mirror, gradient multiply + round), 1 beat/cycle.
// Backpressure: one global enable; the whole pipe freezes while the output holds a beat that is not taken.
//
// Ports:
//   clk, rst (async, active-low)
//   data_in_0 / _valid / _ready    forward inputs x, N lanes of signed Q.FX
//   data_in_1 / _valid / _ready    upstream gradients g, N lanes, signed
//   data_out_0 / _valid / _ready   dL/dx, N lanes, same fractional bits as g
module fixed_softplus_backward #(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 12,
    parameter int DATA_IN_1_PRECISION_0       = 16,
    parameter int DATA_IN_1_PRECISION_1       = 12,
    parameter int DATA_OUT_0_PRECISION_0      = 16,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_1_PRECISION_0-1:0]  data_in_1,
    input  logic data_in_1_valid,
    output logic data_in_1_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready
);

    localparam int N   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int WX  = DATA_IN_0_PRECISION_0;
    localparam int FX  = DATA_IN_0_PRECISION_1;
    localparam int WG  = DATA_IN_1_PRECISION_0;
    localparam int WO  = DATA_OUT_0_PRECISION_0;
    localparam int AW  = WX + 1;          // |x| needs one extra bit for the most-negative x
    localparam int MW  = AW + 17;         // 16-bit coefficient times zero-extended |x|
    localparam int M2W = MW + AW + 1;     // t1 times zero-extended |x|
    localparam int PW  = WG + 17;         // unsigned 16-bit s times signed g

    localparam logic [1:0] SEG0 = 2'd0;
    localparam logic [1:0] SEG1 = 2'd1;
    localparam logic [1:0] SAT  = 2'd2;

    localparam logic [AW-1:0] TH_2 = AW'(2 << FX);
    localparam logic [AW-1:0] TH_4 = AW'(4 << FX);

    localparam logic signed [15:0] S0_A2 = -16'sd973;
    localparam logic signed [15:0] S0_A1 = 16'sd8192;
    localparam logic signed [15:0] S0_A0 = 16'sd16384;
    localparam logic signed [15:0] S1_A2 = -16'sd695;
    localparam logic signed [15:0] S1_A1 = 16'sd5826;
    localparam logic signed [15:0] S1_A0 = 16'sd19988;

    localparam logic signed [PW-1:0] OMAX = PW'((2 ** (WO - 1)) - 1);
    localparam logic signed [PW-1:0] OMIN = PW'(-(2 ** (WO - 1)));

    // The output keeps the gradient's fractional bits (s is Q1.15, shifted back by 15),
    // so that width never enters the arithmetic.
    logic [DATA_IN_1_PRECISION_1-1:0] w_unused_out_frac;
    assign w_unused_out_frac = '0;

    // ---------------- join and global enable ----------------
    logic r_v1, r_v2, r_v3;
    logic w_en, w_fire;

    assign w_en            = !r_v3 || data_out_0_ready;
    assign w_fire          = data_in_0_valid && data_in_1_valid && w_en;
    assign data_in_0_ready = rst && w_en && data_in_1_valid;
    assign data_in_1_ready = rst && w_en && data_in_0_valid;
    assign data_out_0_valid = r_v3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= w_fire;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // ---------------- per-lane datapath ----------------
    for (genvar gl = 0; gl < N; gl++) begin : g_lane
        logic signed [WX-1:0]  w_x;
        logic signed [AW-1:0]  w_xe;
        logic [AW-1:0]         w_a;
        logic [1:0]            w_seg;
        logic signed [15:0]    w_a2, w_a1, w_a0;
        logic signed [MW-1:0]  w_m1, w_t1;
        logic signed [M2W-1:0] w_m2, w_sp;
        logic [15:0]           w_sp_c, w_s;
        logic signed [PW-1:0]  w_p, w_r;
        logic signed [WO-1:0]  w_o;

        logic [AW-1:0]         r_a;
        logic signed [MW-1:0]  r_t1;
        logic                  r_neg1;
        logic [1:0]            r_seg1;
        logic signed [WG-1:0]  r_g1, r_g2;
        logic [15:0]           r_s;
        logic signed [WO-1:0]  r_o;

        // Stage 1: |x|, segment, first Horner step
        assign w_x  = data_in_0[gl*WX +: WX];
        assign w_xe = {w_x[WX-1], w_x};
        assign w_a  = w_x[WX-1] ? -w_xe : w_xe;

        always_comb begin
            w_seg = SAT;
            w_a2  = S1_A2;
            w_a1  = S1_A1;
            if (w_a < TH_2) begin
                w_seg = SEG0;
                w_a2  = S0_A2;
                w_a1  = S0_A1;
            end else if (w_a < TH_4) begin
                w_seg = SEG1;
            end
        end

        assign w_m1 = MW'(w_a2) * MW'($signed({1'b0, w_a}));
        assign w_t1 = (w_m1 >>> FX) + MW'(w_a1);

        // Stage 2: second Horner step, clamp, mirror for negative x
        always_comb begin
            w_a0 = S1_A0;
            if (r_seg1 == SEG0) begin
                w_a0 = S0_A0;
            end
        end

        assign w_m2 = M2W'(r_t1) * M2W'($signed({1'b0, r_a}));
        assign w_sp = (w_m2 >>> FX) + M2W'(w_a0);

        always_comb begin
            w_sp_c = w_sp[15:0];
            if (r_seg1 == SAT || w_sp > M2W'(32767)) begin
                w_sp_c = 16'd32767;
            end else if (w_sp[M2W-1]) begin
                w_sp_c = 16'd0;
            end
        end

        // sigmoid(-x) = 1 - sigmoid(x); 32768 - 0 still fits as unsigned Q1.15
        assign w_s = r_neg1 ? (16'd32768 - w_sp_c) : w_sp_c;

        // Stage 3: scale gradient, round half up, saturate
        assign w_p = PW'($signed({1'b0, r_s})) * PW'(r_g2);
        assign w_r = (w_p + PW'(16384)) >>> 15;

        always_comb begin
            w_o = WO'(w_r);
            if (w_r > OMAX) begin
                w_o = WO'(OMAX);
            end else if (w_r < OMIN) begin
                w_o = WO'(OMIN);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_a    <= '0;
                r_t1   <= '0;
                r_neg1 <= 1'b0;
                r_seg1 <= SEG0;
                r_g1   <= '0;
                r_g2   <= '0;
                r_s    <= '0;
                r_o    <= '0;
            end else if (w_en) begin
                r_a    <= w_a;
                r_t1   <= w_t1;
                r_neg1 <= w_x[WX-1];
                r_seg1 <= w_seg;
                r_g1   <= data_in_1[gl*WG +: WG];
                r_g2   <= r_g1;
                r_s    <= w_s;
                r_o    <= w_o;
            end
        end

        assign data_out_0[gl*WO +: WO] = r_o;
    end

endmodule
